axis_rgb_word_packer: RTL
=========================

Name: axis_rgb_word_packer

Overview:
- Output stage directly downstream of the upsampled-pixel AXI-Stream master of the access-control block.
- Repacks 24-bit RGB pixels (one per beat) into dense 32-bit words for the output DMA: 4 pixels become 3 words, with no padding.
- Regenerates frame markers: tuser on the first word of a frame, tlast on the last word of a line or of a frame.
- Checks the incoming tlast against the programmed geometry.

Parameters:
- PIX_WIDTH, 24, input pixel width; fixed at 24, elaboration error otherwise.
- OUT_WIDTH, 32, output word width; fixed at 32.
- DST_IMG_WIDTH, 3840, pixels per line; must be a multiple of 4, elaboration error otherwise.
- DST_IMG_HEIGHT, 2160, lines per frame.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- s_axis_tvalid  in  1  input pixel valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  24  pixel {R,G,B}, B in bits [7:0].
- s_axis_tlast  in  1  upstream end-of-frame marker.
- s_axis_tuser  in  1  upstream start-of-frame marker.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  32  packed word.
- m_axis_tkeep  out  4  always 4'hF when valid.
- m_axis_tlast  out  1  end of line or frame (see Optional Feature).
- m_axis_tuser  out  1  first word of frame.
- pk_frame_done  out  1  one-cycle pulse when the last word of a frame is accepted downstream.
- pk_err  out  1  sticky geometry error, cleared only by rst.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - m_axis_tvalid, tlast, tuser, pk_frame_done, pk_err = 0; m_axis_tdata = 0.
  - phase=0, residue=0, col=0, row=0.
  - Reset mid-frame discards the residue and any pending word, and returns to phase 0.
- Handshake:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready, in every phase; purely combinational, no other dependency.
  - Input accepted on s_axis_tvalid && s_axis_tready.
  - Output is a single register stage: tvalid, tdata, tlast and tuser are held stable while tvalid && !tready.
- Packing state machine, phase 0..3 = pixel index mod 4, advancing on each accepted pixel:
  - P0: residue[23:0] = p0; no output.
  - P1: emit {p1[7:0], p0}; residue[15:0] = p1[23:8].
  - P2: emit {p2[15:0], res16}; residue[7:0] = p2[23:16].
  - P3: emit {p3, res8}; phase wraps to 0.
- Latency: the word appears on m_axis_tvalid the cycle after the accepting edge. Throughput is 3 words per 4 pixels with no bubbles while tready=1.
- Counters:
  - col counts pixels 0..DST_IMG_WIDTH-1; wraps to 0 and increments row.
  - row wraps to 0 after DST_IMG_HEIGHT-1.
  - Because width%4==0, a line always ends in P3, so no line-end residue exists.
- Markers:
  - m_axis_tuser = 1 on the P1 word when row=0 and col=1.
  - End-of-frame word = P3 word with row=H-1 and col=W-1.
- Error checks:
  - s_axis_tlast=1 on any pixel other than the last of the frame → pk_err=1.
  - s_axis_tlast=0 on the last pixel of the frame → pk_err=1.
  - s_axis_tuser=1 on any pixel other than the first → pk_err=1.
  - Data path continues unaffected; input markers never alter the counters.
- pk_frame_done pulses on the cycle the end-of-frame word handshakes (tvalid && tready && frame-end).
- Back-to-back frames: no idle cycle required between the last word of one frame and the first pixel of the next.

Optional Feature:
- Macro PACKER_LINE_LAST_EN.
- Defined: m_axis_tlast = 1 on the last word of every line (W*3/4 words per packet; DMA line-per-packet mode).
- Undefined: m_axis_tlast = 1 only on the last word of the frame.
- pk_frame_done is identical in both builds.

Decomposition:
- Shared package pk_pkg holds:
  - localparams PK_PIX_W=24, PK_WORD_W=32, PK_PIX_PER_GRP=4, PK_WORD_PER_GRP=3;
  - typedef pk_phase_t (2-bit enum PH0..PH3);
  - typedef pk_rgb_t (packed struct r,g,b).
- One sub-module, pk_geom_counter: col/row counters plus last-of-line, last-of-frame and first-of-frame flags, reusable by upstream stages.

Test Plan:
- Four pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A, tready=1 → words 0x04030201, 0x08070605, 0x0C0B0A09; first word has tuser=1.
- W=8, H=2, continuous stream, tready=1 → 12 words total. tlast on words 6 and 12 with PACKER_LINE_LAST_EN, otherwise on word 12 only. pk_frame_done pulses once.
- Random tready at 50%, W=16, H=4 → output sequence identical to the tready=1 run; stalled word stable; no pixel lost or duplicated.
- s_axis_tlast asserted on pixel 5 of an 8x2 frame → pk_err=1 and stays high; word count still 12.
- rst pulsed after 2 pixels (phase 2), then a clean frame → no residue leaks; first word equals {p1[7:0],p0} of the new frame with tuser=1.
- Two frames back-to-back, no gap → tuser on word 1 of each frame, 2 pk_frame_done pulses.

Source files
------------

// File: rtl/axis_rgb_word_packer_pkg.sv
// Shared types and constants for the RGB word packer and its geometry counter.
// Latency: none (declarations only). Backpressure: n/a.
package pk_pkg;
  localparam int PK_PIX_W        = 24;
  localparam int PK_WORD_W       = 32;
  localparam int PK_PIX_PER_GRP  = 4;
  localparam int PK_WORD_PER_GRP = 3;

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} pk_phase_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pk_rgb_t;
endpackage

// File: rtl/axis_rgb_word_packer_geom_counter.sv
// Column/row position of the pixel currently offered, with first/last flags.
// Latency: flags are combinational from the count; count advances on adv. Backpressure: caller gates adv.
module pk_geom_counter #(
  parameter int IMG_W = 3840,
  parameter int IMG_H = 2160,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          first_of_frame,
  output logic          last_of_line,
  output logic          last_of_frame
);
  import pk_pkg::*;

  assign first_of_frame = (col == '0) && (row == '0);
  assign last_of_line   = (col == CW'(IMG_W - 1));
  assign last_of_frame  = last_of_line && (row == RW'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (last_of_line) begin
        col <= '0;
        row <= last_of_frame ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end
endmodule

// File: rtl/axis_rgb_word_packer.sv
// Packs 24-bit RGB pixels into dense 32-bit words (4 px -> 3 words); PACKER_LINE_LAST_EN adds per-line tlast.
// Latency: 1 cycle from accepting edge to m_axis_tvalid. Backpressure: single output register, s_axis_tready = !m_axis_tvalid || m_axis_tready.
module axis_rgb_word_packer #(
  parameter int PIX_WIDTH      = 24,
  parameter int OUT_WIDTH      = 32,
  parameter int DST_IMG_WIDTH  = 3840,
  parameter int DST_IMG_HEIGHT = 2160
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [PIX_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic [3:0]           m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 pk_frame_done,
  output logic                 pk_err
);
  import pk_pkg::*;

  localparam int CW = (DST_IMG_WIDTH > 1) ? $clog2(DST_IMG_WIDTH) : 1;
  localparam int RW = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;

  if (PIX_WIDTH != PK_PIX_W) begin : g_bad_pix_w
    $error("axis_rgb_word_packer: PIX_WIDTH must be 24");
  end
  if (OUT_WIDTH != PK_WORD_W) begin : g_bad_out_w
    $error("axis_rgb_word_packer: OUT_WIDTH must be 32");
  end
  if ((DST_IMG_WIDTH % PK_PIX_PER_GRP) != 0) begin : g_bad_img_w
    $error("axis_rgb_word_packer: DST_IMG_WIDTH must be a multiple of 4");
  end

  logic          acc;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          first_of_frame;
  logic          last_of_line;
  logic          last_of_frame;

  pk_phase_t     phase_q, phase_d;
  logic [23:0]   res_q, res_d;
  logic [31:0]   word_d;
  logic          word_vld_d;
  logic          word_last_d;
  logic          word_user_d;
  logic          word_eof_d;
  logic          m_eof_q;
  pk_rgb_t       pix;

  assign pix           = s_axis_tdata;
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign m_axis_tkeep  = {4{m_axis_tvalid}};
  assign pk_frame_done = m_axis_tvalid && m_axis_tready && m_eof_q;

  pk_geom_counter #(
    .IMG_W (DST_IMG_WIDTH),
    .IMG_H (DST_IMG_HEIGHT)
  ) u_geom (
    .clk            (clk),
    .rst            (rst),
    .adv            (acc),
    .col            (col),
    .row            (row),
    .first_of_frame (first_of_frame),
    .last_of_line   (last_of_line),
    .last_of_frame  (last_of_frame)
  );

  // Residue is kept right-aligned; each phase consumes it from bit 0 upward.
  always_comb begin
    phase_d     = phase_q;
    res_d       = res_q;
    word_d      = '0;
    word_vld_d  = 1'b0;
    word_eof_d  = (phase_q == PH3) && last_of_frame;
    word_user_d = (phase_q == PH1) && (row == '0) && (col == CW'(1));
`ifdef PACKER_LINE_LAST_EN
    word_last_d = (phase_q == PH3) && last_of_line;
`else
    word_last_d = (phase_q == PH3) && last_of_frame;
`endif
    if (acc) begin
      case (phase_q)
        PH0: begin
          res_d   = pix;
          phase_d = PH1;
        end
        PH1: begin
          word_d     = {pix.b, res_q};
          word_vld_d = 1'b1;
          res_d      = {8'h00, pix.r, pix.g};
          phase_d    = PH2;
        end
        PH2: begin
          word_d     = {pix.g, pix.b, res_q[15:0]};
          word_vld_d = 1'b1;
          res_d      = {16'h0000, pix.r};
          phase_d    = PH3;
        end
        default: begin
          word_d     = {pix, res_q[7:0]};
          word_vld_d = 1'b1;
          phase_d    = PH0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= PH0;
      res_q         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_eof_q       <= 1'b0;
      pk_err        <= 1'b0;
    end else begin
      phase_q <= phase_d;
      res_q   <= res_d;
      if (word_vld_d) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= word_d;
        m_axis_tlast  <= word_last_d;
        m_axis_tuser  <= word_user_d;
        m_eof_q       <= word_eof_d;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      // Input markers are only checked, never used to resynchronise the counters.
      if (acc && ((s_axis_tlast != last_of_frame) || (s_axis_tuser && !first_of_frame))) begin
        pk_err <= 1'b1;
      end
    end
  end
endmodule
